seven_seg_digit_driver: RTL
===========================

# seven_seg_digit_driver

Downstream consumer of the four-digit scan strobe. Takes the active-low one-hot digit enable from the scanner plus a four-digit BCD value and produces registered anode, segment and decimal-point drives for the common-anode display. Updates are double-buffered and committed only at a frame boundary so a displayed time never tears. Per-frame PWM brightness control is included.

## Interface
- No parameters.
- base_scan_clock  in  1  clock; same clock that advances the scanner.
- RESETn  in  1  reset, asynchronous, active-high.
- scan_in  in  4  active-low one-hot digit enable from the scanner: 1110 = digit0 (rightmost) … 0111 = digit3 (leftmost).
- digits_in  in  16  BCD value; [3:0] digit0 … [15:12] digit3.
- dp_in  in  4  decimal point request per digit, active-high, bit i = digit i.
- load  in  1  one-cycle strobe capturing digits_in/dp_in.
- brightness  in  4  duty level, 0 = dimmest (1/16), 15 = full (16/16).
- an_out  out  4  anode drive, active low.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp_out  out  1  decimal point, active low.
- frame_start  out  1  high for the cycle in which an_out = 1110.
- pending  out  1  high while a loaded value awaits commit.

## Operation
- Registers: pend_dig[15:0], pend_dp[3:0], disp_dig[15:0], disp_dp[3:0], bright_q[3:0], frame_cnt[3:0], pending.
- load = 1: pend_* ← inputs, pending ← 1. Later load before commit overwrites.
- Commit edge: edge where scan_in = 0111 is sampled. If pending: disp_* ← pend_*, pending ← 0. If load is also high that edge: disp_* ← digits_in/dp_in directly, pending ← 0.
- Same commit edge: frame_cnt ← frame_cnt + 1 (wraps 15→0), bright_q ← brightness.
- Select: digit i chosen by scan_in = all ones except bit i. Any other scan_in (0 or ≥2 zeros): an_out ← 1111, seg_out ← 1111111, dp_out ← 1.
- Decode 0–9: standard glyphs (0 → 1000000, 1 → 1111001, 8 → 0000000). Values A–F: dash, seg_out = 0111111.
- Lit condition: frame_cnt ≤ bright_q. When unlit: an_out ← 1111, seg/dp all off; frame_start still pulses.
- dp_out ← ~disp_dp[i] when lit and valid.

## Timing
- One-cycle latency: outputs on edge k+1 reflect scan_in sampled at edge k and disp_* as registered before edge k.
- New value first visible on the 1110 output following its commit edge; whole frame uses one value.
- Brightness changes take effect only at the commit edge; never mid-frame.
- Reset (any time, async): an_out 1111, seg_out 1111111, dp_out 1, frame_start 0, pending 0, disp_*/pend_* 0, frame_cnt 0, bright_q 1111. Reset mid-frame discards pending data.
- Scanner stuck or reset held: outputs follow the decode of the held scan_in each cycle; no internal timeout.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digit3 blanked (segments off, anode still asserted) if disp_dig[15:12] = 0 and disp_dp[3] = 0; digit2 blanked if digits 3 and 2 both zero and their dps clear; digit1 likewise for digits 3–1; digit0 never blanked.
- Undefined: all digits always decoded; 0012 shows "0012".

## Test plan
- Reset then free-running scanner, brightness 15, load 1234 -> after commit an_out cycles 1110/1101/1011/0111 one cycle behind scan_in with seg_out 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1); frame_start high with 1110.
- load 5678 while scan_in = 1101 -> pending 1; current frame finishes with 1234; 5678 appears from next 1110 output; pending 0 after commit edge.
- load coincident with scan_in = 0111 -> new value displayed from the next frame, pending never observed high.
- brightness 3 for 32 frames -> exactly 8 lit frames (frame_cnt 0–3 of each 16), others an_out 1111; frame_start still pulses each frame.
- scan_in forced 1100 and 1111 -> an_out 1111, seg_out 1111111 next cycle; digit value 0xB -> 0111111.
- With LEADING_ZERO_BLANK_EN, load 0007 -> digits3–1 segments 1111111, digit0 1111000; with dp_in = 1000 digit3 shows 0 with dp_out 0.

Source files
------------

// File: rtl/seven_seg_digit_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_digit_driver
//
// Drives a four-digit common-anode seven-segment display from the active-low
// one-hot digit strobe of the scanner. A loaded BCD value is double-buffered
// and only committed at the frame boundary (the edge that samples digit3), so
// a displayed value never tears. Per-frame PWM dimming compares a free-running
// frame counter against the brightness captured at the same boundary.
//
// Ports
//   base_scan_clock  in   clock shared with the scanner
//   RESETn           in   asynchronous reset, active-high
//   scan_in[3:0]     in   active-low one-hot digit enable (1110 = digit0)
//   digits_in[15:0]  in   BCD value, [3:0] = digit0 ... [15:12] = digit3
//   dp_in[3:0]       in   decimal point request per digit, active-high
//   load             in   one-cycle strobe capturing digits_in / dp_in
//   brightness[3:0]  in   duty level, 0 = 1/16 ... 15 = 16/16
//   an_out[3:0]      out  anode drive, active low
//   seg_out[6:0]     out  segments {g,f,e,d,c,b,a}, active low
//   dp_out           out  decimal point, active low
//   frame_start      out  high in the cycle where digit0 is presented
//   pending          out  a loaded value is waiting for the frame boundary
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit0 is never blanked; a set decimal point stops blanking).
// -----------------------------------------------------------------------------
module seven_seg_digit_driver (
  input  logic        base_scan_clock,
  input  logic        RESETn,
  input  logic [3:0]  scan_in,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic [3:0]  brightness,
  output logic [3:0]  an_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic        frame_start,
  output logic        pending
);

  logic [15:0] pend_dig_q, pend_dig_d;
  logic [3:0]  pend_dp_q,  pend_dp_d;
  logic [15:0] disp_dig_q, disp_dig_d;
  logic [3:0]  disp_dp_q,  disp_dp_d;
  logic [3:0]  bright_q,   bright_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic        pending_q,  pending_d;

  logic [3:0]  an_q,  an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q,  dp_d;
  logic        fs_q,  fs_d;

  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic [3:0]  sel_val;
  logic        lit;
  logic        blank;
  logic        commit;

  // Active-low glyphs {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Only a strobe with exactly one zero selects a digit.
  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (scan_in)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  assign sel_val = disp_dig_q[{sel_idx, 2'b00} +: 4];
  assign lit     = (frame_cnt_q <= bright_q);
  assign commit  = (scan_in == 4'b0111);

`ifdef LEADING_ZERO_BLANK_EN
  logic z3, z2, z1;
  assign z3 = (disp_dig_q[15:12] == 4'd0) && !disp_dp_q[3];
  assign z2 = (disp_dig_q[11:8]  == 4'd0) && !disp_dp_q[2];
  assign z1 = (disp_dig_q[7:4]   == 4'd0) && !disp_dp_q[1];

  // A digit is blanked only when it and every digit to its left are zero.
  always_comb begin
    blank = 1'b0;
    case (sel_idx)
      2'd3:    blank = z3;
      2'd2:    blank = z3 && z2;
      2'd1:    blank = z3 && z2 && z1;
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Output decode for the digit sampled this edge.
  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    fs_d  = (scan_in == 4'b1110);
    if (sel_valid && lit) begin
      an_d = scan_in;
      dp_d = ~disp_dp_q[sel_idx];
      if (!blank) begin
        seg_d = bcd_to_seg(sel_val);
      end
    end
  end

  // Double buffer and frame-boundary commit. A load on the commit edge goes
  // straight to the display buffer, so pending never rises for it.
  always_comb begin
    pend_dig_d  = pend_dig_q;
    pend_dp_d   = pend_dp_q;
    disp_dig_d  = disp_dig_q;
    disp_dp_d   = disp_dp_q;
    bright_d    = bright_q;
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q;
    if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
    end
    if (commit) begin
      frame_cnt_d = frame_cnt_q + 4'd1;
      bright_d    = brightness;
      pending_d   = 1'b0;
      if (load) begin
        disp_dig_d = digits_in;
        disp_dp_d  = dp_in;
      end else if (pending_q) begin
        disp_dig_d = pend_dig_q;
        disp_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge base_scan_clock or posedge RESETn) begin
    if (RESETn) begin
      pend_dig_q  <= 16'd0;
      pend_dp_q   <= 4'd0;
      disp_dig_q  <= 16'd0;
      disp_dp_q   <= 4'd0;
      bright_q    <= 4'hF;
      frame_cnt_q <= 4'd0;
      pending_q   <= 1'b0;
      an_q        <= 4'hF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      pend_dig_q  <= pend_dig_d;
      pend_dp_q   <= pend_dp_d;
      disp_dig_q  <= disp_dig_d;
      disp_dp_q   <= disp_dp_d;
      bright_q    <= bright_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      fs_q        <= fs_d;
    end
  end

  assign an_out      = an_q;
  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign frame_start = fs_q;
  assign pending     = pending_q;

endmodule
